// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative multiply unit for the execute stage (mult, multu,
// mfhi, mflo). A radix-2 shift-add datapath builds the 2*WIDTH-bit product of
// the operand magnitudes over WIDTH RUN cycles. A single FIX cycle then
// restores the sign and writes the architectural HI/LO registers.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   startE, signedE     mult/multu in execute; 1 = signed (mult)
//   mfreqE              mfhi/mflo in execute (needs a settled HI/LO)
//   flushE              execute flush; blocks acceptance of a new start only
//   srcaE, srcbE        multiplicand, multiplier
//   hi, lo              architectural HI/LO registers
//   busy                unit not idle
//   stallE              busy & (startE | mfreqE); holds the D/E stages
//   done                one-cycle pulse in the cycle after HI/LO is written
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             mfreqE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallE,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nx;
  logic                neg;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH:0]    p;
  logic [CW-1:0]       cnt;

  logic                accept;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH:0]    p_add, p_nx;
  logic [2*WIDTH-1:0]  res;

  assign accept = startE & ~flushE;

  // Unsigned magnitudes. The most negative value negates to itself, which
  // read as unsigned is exactly its magnitude.
  assign a_mag = (signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_mag = (signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;

  // Shift-add step. The (W+1)-bit sum keeps the carry, which lands in the
  // top half after the shift.
  assign sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  assign p_add = p[0] ? {sum, p[WIDTH-1:0]} : p;
  assign p_nx  = p_add >> 1;

  assign res = neg ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];

  assign busy   = (state != IDLE);
  assign stallE = busy & (startE | mfreqE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      neg   <= 1'b0;
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == FIX);
      case (state)
        IDLE: if (accept) begin
          neg   <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          mcand <= a_mag;
          p     <= {{(WIDTH+1){1'b0}}, b_mag};
          cnt   <= CW'(WIDTH);
        end
        RUN: begin
          p   <= p_nx;
          cnt <= cnt - CW'(1);
        end
        FIX: {hi, lo} <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit (WIDTH=32): a table of directed
// products, randomized products against a plain-arithmetic reference, and
// hand-written sequences for reset, stall, flush and back-to-back corners.
module tb_hilo_mult_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         startE = 1'b0, signedE = 1'b0, mfreqE = 1'b0, flushE = 1'b0;
  logic [W-1:0] srcaE = '0, srcbE = '0;
  logic [W-1:0] hi, lo;
  logic         busy, stallE, done;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] cur_hi = '0, cur_lo = '0;

  hilo_mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE),
    .mfreqE(mfreqE), .flushE(flushE), .srcaE(srcaE), .srcbE(srcbE),
    .hi(hi), .lo(lo), .busy(busy), .stallE(stallE), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] eh, el;
  } vec_t;

  // Reference: full-width product in 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive a start on the next negedge; it is taken at the following edge t.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    srcaE = a; srcbE = b; signedE = s; startE = 1'b1;
    @(posedge clk);
    #1 startE = 1'b0;
  endtask

  // Follow one product from edge t to edge t+W+1, checking every cycle.
  task automatic track(input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int mf_from, input int flush_at, input int st2_at,
                       input logic [W-1:0] a2, input logic [W-1:0] b2, input logic s2);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (mf_from >= 0 && k >= mf_from) mfreqE = 1'b1;
      flushE = (k == flush_at);
      if (st2_at >= 0 && k == st2_at) begin
        srcaE = a2; srcbE = b2; signedE = s2; startE = 1'b1;
      end
      #1;
      chk($sformatf("busy k=%0d", k), 64'(busy), 64'(k <= W));
      chk($sformatf("stallE k=%0d", k), 64'(stallE), 64'((k <= W) && (mfreqE || startE)));
      chk($sformatf("done k=%0d", k), 64'(done), 64'(k == W + 1));
      chk($sformatf("hilo k=%0d", k), {hi, lo}, (k <= W) ? {cur_hi, cur_lo} : {eh, el});
    end
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    start_op(a, b, s);
    track(eh, el, -1, -1, -1, '0, '0, 1'b0);
    @(negedge clk); #1;
    chk("done once", 64'(done), 64'(0));
  endtask

  vec_t tbl[10];

  initial begin
    logic [2*W-1:0] r, r2;
    logic [W-1:0]   ra, rb;
    logic           rs;

    tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'hFFFFFFFF};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    tbl[4] = '{32'h80000000, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'h00000000};
    tbl[5] = '{32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 32'h0000000F};
    tbl[6] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[7] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9};
    tbl[8] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000};
    tbl[9] = '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000};

    // Reset state, with requests asserted to show stallE stays low.
    mfreqE = 1'b1; startE = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst stallE", 64'(stallE), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst hilo", {hi, lo}, 64'(0));
    mfreqE = 1'b0; startE = 1'b0; rst = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].eh, tbl[i].el);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ra = 32'h80000000;
      if (i % 8 == 1) rb = 32'hFFFFFFFF;
      r = ref_mul(ra, rb, rs);
      run_op(ra, rb, rs, r[2*W-1:W], r[W-1:0]);
    end

    // Reset mid-RUN aborts with HI/LO cleared, then a fresh product works.
    start_op(32'h12345678, 32'h9ABCDEF1, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst hilo", {hi, lo}, 64'(0));
    cur_hi = '0; cur_lo = '0;
    @(negedge clk); rst = 1'b1;
    run_op(32'd3, 32'd5, 1'b0, 32'd0, 32'd15);

    // mfhi/mflo held from t+5 stalls until busy falls.
    r = ref_mul(32'hDEADBEEF, 32'h01234567, 1'b1);
    start_op(32'hDEADBEEF, 32'h01234567, 1'b1);
    track(r[2*W-1:W], r[W-1:0], 5, -1, -1, '0, '0, 1'b0);
    mfreqE = 1'b0;

    // Second start during RUN stalls, then is taken at edge t+W+2.
    r  = ref_mul(32'h0000FFFF, 32'h0000FFFF, 1'b0);
    r2 = ref_mul(32'hFFFFFF00, 32'h00000100, 1'b1);
    start_op(32'h0000FFFF, 32'h0000FFFF, 1'b0);
    track(r[2*W-1:W], r[W-1:0], -1, -1, 3, 32'hFFFFFF00, 32'h00000100, 1'b1);
    @(posedge clk);
    #1 startE = 1'b0;
    track(r2[2*W-1:W], r2[W-1:0], -1, -1, -1, '0, '0, 1'b0);

    // Start together with flush is dropped.
    @(negedge clk);
    srcaE = 32'h11111111; srcbE = 32'h22222222; signedE = 1'b0;
    startE = 1'b1; flushE = 1'b1;
    @(posedge clk);
    #1 startE = 1'b0; flushE = 1'b0;
    @(negedge clk);
    chk("flushstart busy", 64'(busy), 64'(0));
    chk("flushstart hilo", {hi, lo}, {cur_hi, cur_lo});

    // Flush during RUN does not abort.
    r = ref_mul(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    track(r[2*W-1:W], r[W-1:0], -1, 10, -1, '0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
